// File: rtl/shift_sched_pkg.sv
// Shared types and defaults for the two-requester shift scheduler.
package shift_sched_pkg;

  localparam int TAG_W_DEF = 4;
  localparam int CNT_W_DEF = 16;
  // Ops carry the widest tag a top may ask for; the top keeps only TAG_W bits.
  localparam int TAG_W_MAX = 16;

  localparam int REQ_LO = 0;
  localparam int REQ_HI = 1;

  typedef struct packed {
    logic                 wide;
    logic                 dir;
    logic                 arith;
    logic [5:0]           amt;
    logic [63:0]          data;
    logic [TAG_W_MAX-1:0] tag;
  } op_t;

  function automatic logic [31:0] sh32(input logic [31:0] d, input logic [4:0] a,
                                       input logic dir, input logic arith);
    if (!dir) return d << a;
    if (arith) return $signed(d) >>> a;
    return d >> a;
  endfunction

endpackage

// File: rtl/shift64.sv
// Split/unified 64-bit shifter: one 64-bit shift, or two independent 32-bit halves.
// Purely combinational; the caller registers the result.
module shift64
  import shift_sched_pkg::*;
(
  input  logic [63:0] data,
  input  logic [10:0] amt,
  input  logic        split,
  input  logic [1:0]  dir,
  input  logic [1:0]  arith,
  output logic [63:0] res
);

  logic [63:0] uni;
  logic [31:0] lo;
  logic [31:0] hi;

  // Unified mode is steered by the low-half controls; amt[5] is the 32 bit.
  always_comb begin
    uni = '0;
    if (!dir[0]) uni = data << amt[5:0];
    else if (arith[0]) uni = $signed(data) >>> amt[5:0];
    else uni = data >> amt[5:0];
  end

  assign lo  = sh32(data[31:0],  amt[4:0],  dir[0], arith[0]);
  assign hi  = sh32(data[63:32], amt[10:6], dir[1], arith[1]);
  assign res = split ? {hi, lo} : uni;

endmodule

// File: rtl/shift_sched.sv
// Two requesters share one shift64; 32-bit pairs issue together, else round-robin.
// Result registered with 1-cycle latency; a held response blocks only its own requester.
module shift_sched
  import shift_sched_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_wide,
  input  logic [1:0]            req_dir,
  input  logic [1:0]            req_arith,
  input  logic [1:0][5:0]       req_amt,
  input  logic [1:0][63:0]      req_data,
  input  logic [1:0][TAG_W-1:0] req_tag,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [1:0][63:0]      rsp_data,
  output logic [1:0][TAG_W-1:0] rsp_tag,
  output logic [CNT_W-1:0]      pair_cnt
);

  op_t         op [2];
  logic [1:0]  slot_ok;
  logic [1:0]  cand;
  logic [1:0]  grant;
  logic        pair;
  logic        contend;
  logic        rr;

  logic [63:0] sh_data;
  logic [10:0] sh_amt;
  logic        sh_split;
  logic [1:0]  sh_dir;
  logic [1:0]  sh_arith;
  logic [63:0] sh_res;
  logic [63:0] rsp_nxt [2];
  logic        unused_tag_hi;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      op[i].wide  = req_wide[i];
      op[i].dir   = req_dir[i];
      op[i].arith = req_arith[i];
      op[i].amt   = req_amt[i];
      op[i].data  = req_data[i];
      op[i].tag   = TAG_W_MAX'(req_tag[i]);
    end
  end

  assign unused_tag_hi = ^{op[REQ_LO].tag, op[REQ_HI].tag};

  assign slot_ok = ~rsp_valid | rsp_ready;
  assign cand    = req_valid & slot_ok;
  assign pair    = (&cand) & ~(|req_wide);
  assign contend = (&cand) & ~pair;

  always_comb begin
    grant = 2'b00;
    if (!rst_n) grant = 2'b00;
    else if (pair) grant = 2'b11;
    else if (cand == 2'b01) grant = 2'b01;
    else if (cand == 2'b10) grant = 2'b10;
    else if (contend) grant = rr ? 2'b10 : 2'b01;
  end

  assign req_ready = grant;

  // A 32-bit op always lands on its owner's half, so pairs need no extra steering.
  always_comb begin
    sh_data  = '0;
    sh_amt   = '0;
    sh_split = 1'b1;
    sh_dir   = '0;
    sh_arith = '0;
    if (grant[REQ_LO] && op[REQ_LO].wide) begin
      sh_split = 1'b0;
      sh_data  = op[REQ_LO].data;
      sh_amt   = {5'b0, op[REQ_LO].amt};
      sh_dir   = {2{op[REQ_LO].dir}};
      sh_arith = {2{op[REQ_LO].arith}};
    end else if (grant[REQ_HI] && op[REQ_HI].wide) begin
      sh_split = 1'b0;
      sh_data  = op[REQ_HI].data;
      sh_amt   = {5'b0, op[REQ_HI].amt};
      sh_dir   = {2{op[REQ_HI].dir}};
      sh_arith = {2{op[REQ_HI].arith}};
    end else begin
      if (grant[REQ_LO]) begin
        sh_data[31:0] = op[REQ_LO].data[31:0];
        sh_amt[4:0]   = op[REQ_LO].amt[4:0];
        sh_dir[0]     = op[REQ_LO].dir;
        sh_arith[0]   = op[REQ_LO].arith;
      end
      if (grant[REQ_HI]) begin
        sh_data[63:32] = op[REQ_HI].data[31:0];
        sh_amt[10:6]   = op[REQ_HI].amt[4:0];
        sh_dir[1]      = op[REQ_HI].dir;
        sh_arith[1]    = op[REQ_HI].arith;
      end
    end
  end

  shift64 u_shift64 (
    .data  (sh_data),
    .amt   (sh_amt),
    .split (sh_split),
    .dir   (sh_dir),
    .arith (sh_arith),
    .res   (sh_res)
  );

  assign rsp_nxt[REQ_LO] = op[REQ_LO].wide ? sh_res : {32'b0, sh_res[31:0]};
  assign rsp_nxt[REQ_HI] = op[REQ_HI].wide ? sh_res : {32'b0, sh_res[63:32]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_tag   <= '0;
      rr        <= 1'b0;
      pair_cnt  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (grant[i]) begin
          rsp_valid[i] <= 1'b1;
          rsp_data[i]  <= rsp_nxt[i];
          rsp_tag[i]   <= op[i].tag[TAG_W-1:0];
        end else if (rsp_ready[i]) begin
          rsp_valid[i] <= 1'b0;
        end
      end
      if (contend) rr <= ~rr;
      if (pair && pair_cnt != {CNT_W{1'b1}}) pair_cnt <= pair_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_shift_sched.sv
// Directed self-checking bench for shift_sched (CNT_W=2 so saturation is reachable).
module tb_shift_sched;

  localparam int TAG_W = 4;
  localparam int CNT_W = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [1:0]            req_valid, req_ready, req_wide, req_dir, req_arith;
  logic [1:0][5:0]       req_amt;
  logic [1:0][63:0]      req_data;
  logic [1:0][TAG_W-1:0] req_tag;
  logic [1:0]            rsp_valid, rsp_ready;
  logic [1:0][63:0]      rsp_data;
  logic [1:0][TAG_W-1:0] rsp_tag;
  logic [CNT_W-1:0]      pair_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  shift_sched #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wide  (req_wide),
    .req_dir   (req_dir),
    .req_arith (req_arith),
    .req_amt   (req_amt),
    .req_data  (req_data),
    .req_tag   (req_tag),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_tag   (rsp_tag),
    .pair_cnt  (pair_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic wide, input logic dir, input logic arith,
                         input logic [5:0] amt, input logic [63:0] data, input logic [TAG_W-1:0] tag);
    req_wide[i]  = wide;
    req_dir[i]   = dir;
    req_arith[i] = arith;
    req_amt[i]   = amt;
    req_data[i]  = data;
    req_tag[i]   = tag;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 2'b00;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b1;
    req_valid = 2'b00;
    req_wide  = 2'b00;
    req_dir   = 2'b00;
    req_arith = 2'b00;
    req_amt   = '0;
    req_data  = '0;
    req_tag   = '0;
    rsp_ready = 2'b11;
    #2 rst_n = 1'b0;
    req_valid = 2'b11;
    step();
    step();
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data0", rsp_data[0], 64'd0);
    check("rst_rsp_tag1", 64'(rsp_tag[1]), 64'd0);
    check("rst_pair_cnt", 64'(pair_cnt), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    req_valid = 2'b00;
    rst_n = 1'b1;

    // Pairing of two 32-bit ops
    set_req(0, 1'b0, 1'b0, 1'b0, 6'd4, 64'h1, 4'd3);
    set_req(1, 1'b0, 1'b1, 1'b1, 6'd4, 64'h8000_0000, 4'd5);
    req_valid = 2'b11;
    #1 check("pair_ready", 64'(req_ready), 64'h3);
    step();
    check("pair_valid", 64'(rsp_valid), 64'h3);
    check("pair_rsp0", rsp_data[0], 64'h10);
    check("pair_rsp1", rsp_data[1], 64'h0000_0000_F800_0000);
    check("pair_tag0", 64'(rsp_tag[0]), 64'd3);
    check("pair_tag1", 64'(rsp_tag[1]), 64'd5);
    check("pair_cnt1", 64'(pair_cnt), 64'd1);

    // Contention between two 64-bit ops: grants 0,1,0
    set_req(0, 1'b1, 1'b0, 1'b0, 6'd1, 64'h3, 4'd1);
    set_req(1, 1'b1, 1'b1, 1'b0, 6'd1, 64'h10, 4'd2);
    req_valid = 2'b11;
    #1 check("cont_ready_a", 64'(req_ready), 64'h1);
    step();
    check("cont_valid_a", 64'(rsp_valid), 64'h1);
    check("cont_rsp0_a", rsp_data[0], 64'h6);
    #1 check("cont_ready_b", 64'(req_ready), 64'h2);
    step();
    check("cont_valid_b", 64'(rsp_valid), 64'h2);
    check("cont_rsp1_b", rsp_data[1], 64'h8);
    check("cont_tag1_b", 64'(rsp_tag[1]), 64'd2);
    #1 check("cont_ready_c", 64'(req_ready), 64'h1);
    step();
    check("cont_valid_c", 64'(rsp_valid), 64'h1);
    req_valid = 2'b00;
    step();
    check("drain_idle", 64'(rsp_valid), 64'h0);

    // Backpressure on requester 0
    rsp_ready = 2'b10;
    set_req(0, 1'b0, 1'b0, 1'b0, 6'd0, 64'hAA, 4'd7);
    req_valid = 2'b01;
    step();
    set_req(0, 1'b0, 1'b0, 1'b0, 6'd0, 64'hBB, 4'd8);
    set_req(1, 1'b0, 1'b0, 1'b0, 6'd1, 64'h55, 4'd9);
    req_valid = 2'b11;
    #1 check("bp_ready", 64'(req_ready), 64'h2);
    step();
    check("bp_hold_rsp0", rsp_data[0], 64'hAA);
    check("bp_hold_tag0", 64'(rsp_tag[0]), 64'd7);
    check("bp_rsp1", rsp_data[1], 64'hAA);
    check("bp_valid", 64'(rsp_valid), 64'h3);
    req_valid = 2'b01;
    rsp_ready = 2'b11;
    #1 check("bp_drain_ready", 64'(req_ready), 64'h1);
    step();
    check("bp_new_rsp0", rsp_data[0], 64'hBB);
    check("bp_new_tag0", 64'(rsp_tag[0]), 64'd8);
    check("bp_new_valid", 64'(rsp_valid), 64'h1);
    req_valid = 2'b00;
    step();

    // Unified and single-half boundaries
    set_req(0, 1'b1, 1'b1, 1'b1, 6'd63, 64'h8000_0000_0000_0000, 4'd1);
    req_valid = 2'b01;
    step();
    check("uni_asr63", rsp_data[0], 64'hFFFF_FFFF_FFFF_FFFF);
    set_req(1, 1'b1, 1'b0, 1'b0, 6'd32, 64'h1, 4'd2);
    req_valid = 2'b10;
    step();
    check("uni_shl32", rsp_data[1], 64'h0000_0001_0000_0000);
    set_req(0, 1'b1, 1'b1, 1'b0, 6'd0, 64'h1234_5678_9ABC_DEF0, 4'd3);
    req_valid = 2'b01;
    step();
    check("uni_amt0", rsp_data[0], 64'h1234_5678_9ABC_DEF0);
    set_req(1, 1'b0, 1'b1, 1'b0, 6'd31, 64'hDEAD_BEEF_8000_0000, 4'd4);
    req_valid = 2'b10;
    step();
    check("hi32_shr31", rsp_data[1], 64'h1);
    req_valid = 2'b00;
    step();

    // Asynchronous reset while both responses are held
    rsp_ready = 2'b00;
    set_req(0, 1'b0, 1'b0, 1'b0, 6'd1, 64'h1, 4'd6);
    set_req(1, 1'b0, 1'b0, 1'b0, 6'd2, 64'h1, 4'd7);
    req_valid = 2'b11;
    step();
    check("mid_valid", 64'(rsp_valid), 64'h3);
    check("mid_blocked", 64'(req_ready), 64'h0);
    #2 rst_n = 1'b0;
    #1 check("arst_valid", 64'(rsp_valid), 64'h0);
    check("arst_data1", rsp_data[1], 64'h0);
    check("arst_tag0", 64'(rsp_tag[0]), 64'h0);
    check("arst_cnt", 64'(pair_cnt), 64'h0);
    check("arst_ready", 64'(req_ready), 64'h0);
    step();
    rst_n = 1'b1;
    rsp_ready = 2'b11;
    #1 check("post_rst_ready", 64'(req_ready), 64'h3);
    step();
    check("post_rst_rsp1", rsp_data[1], 64'h4);
    check("post_rst_cnt", 64'(pair_cnt), 64'h1);

    // Counter saturation from a fresh reset
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_req(0, 1'b0, 1'b0, 1'b0, 6'd0, 64'(k), 4'(k));
      set_req(1, 1'b0, 1'b0, 1'b0, 6'd0, 64'(k), 4'(k));
      req_valid = 2'b11;
      step();
      check("sat_cnt", 64'(pair_cnt), 64'((k + 1 > 3) ? 3 : k + 1));
    end
    req_valid = 2'b00;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
